// File: rtl/segway_ride_seq.sv
`default_nettype none
// ============================================================================
//  Module   : segway_ride_seq
//  Purpose  : Ride sequencer driving pwr_up, soft-start ss_tmr and en_steer
//             from rider load qualification and the too_fast flag.
//             Optional macro SS_RAMP_DOWN_EN adds a soft ramp-down state.
//  Revision : 1.0  initial release
// ============================================================================
module segway_ride_seq #(
    parameter int          SS_PRESCALE  = 1024,
    parameter int          STEER_HOLD   = 25000000,
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_req,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        too_fast,
    output logic        pwr_up,
    output logic [7:0]  ss_tmr,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int c_PS_W = (SS_PRESCALE > 1) ? $clog2(SS_PRESCALE) : 1;
    localparam int c_ST_W = (STEER_HOLD > 1) ? $clog2(STEER_HOLD) : 1;

    localparam logic [c_PS_W-1:0] c_PS_TC  = c_PS_W'(SS_PRESCALE - 1);
    localparam logic [c_ST_W-1:0] c_ST_TC  = c_ST_W'(STEER_HOLD - 1);
    localparam logic [12:0]       c_WT_ON  = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0]       c_WT_OFF = {1'b0, MIN_RIDER_WT - WT_HYST};

    localparam logic [2:0] c_S_OFF   = 3'd0;
    localparam logic [2:0] c_S_RAMP  = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_STEER = 3'd3;
`ifdef SS_RAMP_DOWN_EN
    localparam logic [2:0] c_S_RAMP_DN = 3'd4;
    localparam logic [2:0] c_S_DROP    = c_S_RAMP_DN;
`else
    localparam logic [2:0] c_S_DROP    = c_S_OFF;
`endif

    logic [2:0]        r_state;
    logic [11:0]       r_lft;
    logic [11:0]       r_rght;
    logic              r_rider_present;
    logic [c_PS_W-1:0] r_ps_cnt;
    logic [c_ST_W-1:0] r_st_cnt;
    logic              r_pwr_up;
    logic [7:0]        r_ss_tmr;
    logic              r_en_steer;
    logic              r_rider_off;

    logic [11:0]       w_lft;
    logic [11:0]       w_rght;
    logic [12:0]       w_sum;
    logic [11:0]       w_diff;
    logic              w_balanced;
    logic              w_rider_nxt;
    logic              w_qualified;
    logic              w_ps_tc;
    logic [2:0]        w_state_nxt;
    logic [c_PS_W-1:0] w_ps_nxt;
    logic [c_ST_W-1:0] w_st_nxt;
    logic [7:0]        w_ss_nxt;
    logic              w_pwr_nxt;
    logic              w_en_nxt;
    logic              w_rider_off_nxt;

    // A fresh sample is evaluated in the clock it arrives so decisions land one clock later.
    assign w_lft      = ld_vld ? lft_ld  : r_lft;
    assign w_rght     = ld_vld ? rght_ld : r_rght;
    assign w_sum      = {1'b0, w_lft} + {1'b0, w_rght};
    assign w_diff     = (w_lft >= w_rght) ? (w_lft - w_rght) : (w_rght - w_lft);
    assign w_balanced = ({1'b0, w_diff} < (w_sum >> 2));

    always_comb begin
        w_rider_nxt = r_rider_present;
        if (w_sum > c_WT_ON) begin
            w_rider_nxt = 1'b1;
        end else if (w_sum < c_WT_OFF) begin
            w_rider_nxt = 1'b0;
        end
    end

    assign w_qualified = w_rider_nxt & w_balanced & ~too_fast;
    assign w_ps_tc     = (r_ps_cnt == c_PS_TC);

    always_comb begin
        w_state_nxt = r_state;
        w_ps_nxt    = '0;
        w_st_nxt    = '0;
        w_ss_nxt    = r_ss_tmr;

        case (r_state)
            c_S_OFF: begin
                w_ss_nxt = '0;
                if (pwr_req) begin
                    w_state_nxt = c_S_RAMP;
                end
            end

            c_S_RAMP: begin
                if (!pwr_req) begin
                    w_state_nxt = c_S_DROP;
                end else if (r_ss_tmr == 8'hFF) begin
                    w_state_nxt = c_S_WAIT;
                end else if (w_ps_tc) begin
                    w_ss_nxt = r_ss_tmr + 8'd1;
                    if (r_ss_tmr == 8'hFE) begin
                        w_state_nxt = c_S_WAIT;
                    end
                end else begin
                    w_ps_nxt = r_ps_cnt + 1'b1;
                end
            end

            c_S_WAIT: begin
                if (!pwr_req) begin
                    w_state_nxt = c_S_DROP;
                end else if (w_qualified) begin
                    if (r_st_cnt == c_ST_TC) begin
                        w_state_nxt = c_S_STEER;
                    end else begin
                        w_st_nxt = r_st_cnt + 1'b1;
                    end
                end
            end

            c_S_STEER: begin
                if (!pwr_req) begin
                    w_state_nxt = c_S_DROP;
                end else if (!w_qualified) begin
                    w_state_nxt = c_S_WAIT;
                end
            end

`ifdef SS_RAMP_DOWN_EN
            c_S_RAMP_DN: begin
                if (pwr_req) begin
                    w_state_nxt = c_S_RAMP;
                end else if (r_ss_tmr == 8'h00) begin
                    w_state_nxt = c_S_OFF;
                end else if (w_ps_tc) begin
                    w_ss_nxt = r_ss_tmr - 8'd1;
                end else begin
                    w_ps_nxt = r_ps_cnt + 1'b1;
                end
            end
`endif

            default: begin
                w_state_nxt = c_S_OFF;
            end
        endcase

        if (w_state_nxt == c_S_OFF) begin
            w_ss_nxt = '0;
        end

        w_pwr_nxt       = (w_state_nxt != c_S_OFF);
        w_en_nxt        = (w_state_nxt == c_S_STEER);
        w_rider_off_nxt = w_pwr_nxt & ~w_rider_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_S_OFF;
            r_lft           <= '0;
            r_rght          <= '0;
            r_rider_present <= 1'b0;
            r_ps_cnt        <= '0;
            r_st_cnt        <= '0;
            r_pwr_up        <= 1'b0;
            r_ss_tmr        <= '0;
            r_en_steer      <= 1'b0;
            r_rider_off     <= 1'b0;
        end else begin
            if (ld_vld) begin
                r_lft  <= lft_ld;
                r_rght <= rght_ld;
            end
            r_state         <= w_state_nxt;
            r_rider_present <= w_rider_nxt;
            r_ps_cnt        <= w_ps_nxt;
            r_st_cnt        <= w_st_nxt;
            r_pwr_up        <= w_pwr_nxt;
            r_ss_tmr        <= w_ss_nxt;
            r_en_steer      <= w_en_nxt;
            r_rider_off     <= w_rider_off_nxt;
        end
    end

    assign pwr_up    = r_pwr_up;
    assign ss_tmr    = r_ss_tmr;
    assign en_steer  = r_en_steer;
    assign rider_off = r_rider_off;

endmodule
`default_nettype wire

// File: tb/tb_segway_ride_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_segway_ride_seq
//  Purpose  : Directed self-checking bench for segway_ride_seq
//             (SS_PRESCALE=4, STEER_HOLD=8, default weights).
//  Revision : 1.0  initial release
// ============================================================================
module tb_segway_ride_seq;

    logic        clk;
    logic        rst_n;
    logic        pwr_req;
    logic        ld_vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        too_fast;
    logic        pwr_up;
    logic [7:0]  ss_tmr;
    logic        en_steer;
    logic        rider_off;

    int n_pass  = 0;
    int n_total = 0;

    segway_ride_seq #(
        .SS_PRESCALE (4),
        .STEER_HOLD  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwr_req   (pwr_req),
        .ld_vld    (ld_vld),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .too_fast  (too_fast),
        .pwr_up    (pwr_up),
        .ss_tmr    (ss_tmr),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
        ld_vld  = 1'b1;
        step(1);
        ld_vld  = 1'b0;
    endtask

    task automatic do_reset;
        pwr_req  = 1'b0;
        ld_vld   = 1'b0;
        too_fast = 1'b0;
        lft_ld   = '0;
        rght_ld  = '0;
        rst_n    = 1'b0;
        step(2);
        rst_n    = 1'b1;
        step(1);
    endtask

    task automatic test_reset;
        do_reset();
        n_total++; if ({pwr_up, ss_tmr, en_steer, rider_off} !== 11'h000)
            $display("FAIL reset_outputs: got %h expected 000", {pwr_up, ss_tmr, en_steer, rider_off});
        else n_pass++;
        step(3);
        n_total++; if (pwr_up !== 1'b0) $display("FAIL off_idle_pwr_up: got %b expected 0", pwr_up);
        else n_pass++;
    endtask

    task automatic test_ramp_up;
        pwr_req = 1'b1;
        step(1);
        n_total++; if (pwr_up !== 1'b1) $display("FAIL ramp_pwr_up: got %b expected 1", pwr_up);
        else n_pass++;
        n_total++; if (rider_off !== 1'b1) $display("FAIL ramp_rider_off: got %b expected 1", rider_off);
        else n_pass++;
        step(3);
        n_total++; if (ss_tmr !== 8'h00) $display("FAIL ramp_ss_plus3: got %h expected 00", ss_tmr);
        else n_pass++;
        step(1);
        n_total++; if (ss_tmr !== 8'h01) $display("FAIL ramp_ss_plus4: got %h expected 01", ss_tmr);
        else n_pass++;
        step(252);
        n_total++; if (ss_tmr !== 8'h40) $display("FAIL ramp_ss_plus256: got %h expected 40", ss_tmr);
        else n_pass++;
        n_total++; if (en_steer !== 1'b0) $display("FAIL ramp_en_steer: got %b expected 0", en_steer);
        else n_pass++;
        step(763);
        n_total++; if (ss_tmr !== 8'hFE) $display("FAIL ramp_ss_plus1019: got %h expected fe", ss_tmr);
        else n_pass++;
        step(1);
        n_total++; if (ss_tmr !== 8'hFF) $display("FAIL ramp_ss_plus1020: got %h expected ff", ss_tmr);
        else n_pass++;
        step(3);
        n_total++; if ({ss_tmr, en_steer} !== 9'h1FE)
            $display("FAIL ramp_saturate: got %h expected 1fe", {ss_tmr, en_steer});
        else n_pass++;
    endtask

    task automatic test_steer_enable;
        load(12'h300, 12'h300);
        step(6);
        n_total++; if (en_steer !== 1'b0) $display("FAIL steer_q7: got %b expected 0", en_steer);
        else n_pass++;
        step(1);
        n_total++; if (en_steer !== 1'b1) $display("FAIL steer_q8: got %b expected 1", en_steer);
        else n_pass++;
        n_total++; if (rider_off !== 1'b0) $display("FAIL steer_rider_off: got %b expected 0", rider_off);
        else n_pass++;
    endtask

    task automatic test_load_hold;
        lft_ld  = 12'hFFF;
        rght_ld = 12'h000;
        step(3);
        n_total++; if (en_steer !== 1'b1) $display("FAIL load_hold: got %b expected 1", en_steer);
        else n_pass++;
    endtask

    task automatic test_imbalance;
        load(12'h500, 12'h100);
        n_total++; if (en_steer !== 1'b0) $display("FAIL imbal_drop: got %b expected 0", en_steer);
        else n_pass++;
        load(12'h300, 12'h300);
        step(6);
        n_total++; if (en_steer !== 1'b0) $display("FAIL imbal_q7: got %b expected 0", en_steer);
        else n_pass++;
        step(1);
        n_total++; if (en_steer !== 1'b1) $display("FAIL imbal_q8: got %b expected 1", en_steer);
        else n_pass++;
    endtask

    task automatic test_hysteresis;
        load(12'h0F8, 12'h0F8);
        n_total++; if ({en_steer, rider_off} !== 2'b10)
            $display("FAIL hyst_hold: got %b expected 10", {en_steer, rider_off});
        else n_pass++;
        load(12'h0D8, 12'h0D8);
        n_total++; if ({en_steer, rider_off} !== 2'b01)
            $display("FAIL hyst_clear: got %b expected 01", {en_steer, rider_off});
        else n_pass++;
        n_total++; if ({pwr_up, ss_tmr} !== 9'h1FF)
            $display("FAIL hyst_ss: got %h expected 1ff", {pwr_up, ss_tmr});
        else n_pass++;
        load(12'h300, 12'h300);
        step(7);
        n_total++; if ({en_steer, rider_off} !== 2'b10)
            $display("FAIL hyst_restore: got %b expected 10", {en_steer, rider_off});
        else n_pass++;
    endtask

    task automatic test_too_fast;
        too_fast = 1'b1;
        step(1);
        too_fast = 1'b0;
        n_total++; if (en_steer !== 1'b0) $display("FAIL tf_drop: got %b expected 0", en_steer);
        else n_pass++;
        n_total++; if ({pwr_up, ss_tmr} !== 9'h1FF)
            $display("FAIL tf_ss: got %h expected 1ff", {pwr_up, ss_tmr});
        else n_pass++;
        step(7);
        n_total++; if (en_steer !== 1'b0) $display("FAIL tf_q7: got %b expected 0", en_steer);
        else n_pass++;
        step(1);
        n_total++; if (en_steer !== 1'b1) $display("FAIL tf_q8: got %b expected 1", en_steer);
        else n_pass++;
        // drop again, then interrupt the count at timer=5
        too_fast = 1'b1;
        step(1);
        too_fast = 1'b0;
        step(5);
        too_fast = 1'b1;
        step(1);
        too_fast = 1'b0;
        step(7);
        n_total++; if (en_steer !== 1'b0) $display("FAIL tf_restart_q7: got %b expected 0", en_steer);
        else n_pass++;
        step(1);
        n_total++; if (en_steer !== 1'b1) $display("FAIL tf_restart_q8: got %b expected 1", en_steer);
        else n_pass++;
    endtask

    task automatic test_pwr_drop;
        pwr_req = 1'b0;
        step(1);
`ifdef SS_RAMP_DOWN_EN
        n_total++; if ({pwr_up, ss_tmr, en_steer} !== 10'h3FE)
            $display("FAIL drop_rampdn_entry: got %h expected 3fe", {pwr_up, ss_tmr, en_steer});
        else n_pass++;
        step(3);
        n_total++; if (ss_tmr !== 8'hFF) $display("FAIL drop_rampdn_d3: got %h expected ff", ss_tmr);
        else n_pass++;
        step(1);
        n_total++; if (ss_tmr !== 8'hFE) $display("FAIL drop_rampdn_d4: got %h expected fe", ss_tmr);
        else n_pass++;
        pwr_req = 1'b1;
        step(4);
        n_total++; if (ss_tmr !== 8'hFE) $display("FAIL drop_reramp_r3: got %h expected fe", ss_tmr);
        else n_pass++;
        step(1);
        n_total++; if ({pwr_up, ss_tmr} !== 9'h1FF)
            $display("FAIL drop_reramp_r4: got %h expected 1ff", {pwr_up, ss_tmr});
        else n_pass++;
`else
        n_total++; if ({pwr_up, ss_tmr, en_steer, rider_off} !== 11'h000)
            $display("FAIL drop_off: got %h expected 000", {pwr_up, ss_tmr, en_steer, rider_off});
        else n_pass++;
`endif
        do_reset();
    endtask

    task automatic test_ramp_drop;
        pwr_req = 1'b1;
        step(257);
        n_total++; if (ss_tmr !== 8'h40) $display("FAIL rdrop_setup: got %h expected 40", ss_tmr);
        else n_pass++;
        pwr_req = 1'b0;
        step(1);
`ifdef SS_RAMP_DOWN_EN
        n_total++; if ({pwr_up, ss_tmr} !== 9'h140)
            $display("FAIL rdrop_entry: got %h expected 140", {pwr_up, ss_tmr});
        else n_pass++;
        step(4);
        n_total++; if (ss_tmr !== 8'h3F) $display("FAIL rdrop_d4: got %h expected 3f", ss_tmr);
        else n_pass++;
        step(252);
        n_total++; if ({pwr_up, ss_tmr} !== 9'h100)
            $display("FAIL rdrop_d256: got %h expected 100", {pwr_up, ss_tmr});
        else n_pass++;
        step(1);
        n_total++; if (pwr_up !== 1'b0) $display("FAIL rdrop_d257: got %b expected 0", pwr_up);
        else n_pass++;
`else
        n_total++; if ({pwr_up, ss_tmr} !== 9'h000)
            $display("FAIL rdrop_off: got %h expected 000", {pwr_up, ss_tmr});
        else n_pass++;
`endif
        pwr_req = 1'b1;
        step(1);
        n_total++; if ({pwr_up, ss_tmr} !== 9'h100)
            $display("FAIL rdrop_restart: got %h expected 100", {pwr_up, ss_tmr});
        else n_pass++;
        step(4);
        n_total++; if (ss_tmr !== 8'h01) $display("FAIL rdrop_restart_p4: got %h expected 01", ss_tmr);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if ({pwr_up, ss_tmr, en_steer, rider_off} !== 11'h000)
            $display("FAIL async_reset: got %h expected 000", {pwr_up, ss_tmr, en_steer, rider_off});
        else n_pass++;
        pwr_req = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);
        n_total++; if (pwr_up !== 1'b0) $display("FAIL async_reset_release: got %b expected 0", pwr_up);
        else n_pass++;
    endtask

    initial begin
        rst_n    = 1'b0;
        pwr_req  = 1'b0;
        ld_vld   = 1'b0;
        lft_ld   = '0;
        rght_ld  = '0;
        too_fast = 1'b0;
        test_reset();
        test_ramp_up();
        test_steer_enable();
        test_load_hold();
        test_imbalance();
        test_hysteresis();
        test_too_fast();
        test_pwr_drop();
        test_ramp_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
